lieat_bjp_bht_ctrl: RTL and testbench
=====================================

# lieat_bjp_bht_ctrl

Branch history table (BHT) controller for the branch/jump path. It holds 32 two-bit saturating direction counters and serves a per-cycle direction lookup to the IFU, indexed by fetch PC bits [6:2]. It trains the counters from the BJP stage-2 resolution port (`bjp_prdt_en` / `bjp_prdt_index` / `bjp_prdt_res`) and counts resolved branches and direction mispredicts (`bjp_prdt_flush`) for performance monitoring. It sits between the BJP unit and the IFU next-PC logic.

## Interface
Parameters:
- `BHT_DEPTH`, 32: number of counters; must be 2^`BHT_IDX`.
- `BHT_IDX`, 5: index width, taken from PC[`BHT_IDX`+1:2].
- `CNT_W`, 32: width of each performance counter.

Ports:
- `clock`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `ifu_lkp_valid`  in  1: a lookup request is present this cycle.
- `ifu_lkp_pc`  in  `XLEN`: fetch PC; the index is `ifu_lkp_pc[6:2]`.
- `ifu_lkp_taken`  out  1: predicted direction, equal to counter[1].
- `ifu_lkp_hit_upd`  out  1: the lookup index equals the index being trained this cycle.
- `bjp_prdt_en`  in  1: a conditional branch resolved; train the counter.
- `bjp_prdt_index`  in  `BHT_IDX`: index to train.
- `bjp_prdt_res`  in  1: resolved direction; 1 means taken.
- `bjp_prdt_flush`  in  1: direction mispredict; redirect issued.
- `bht_en`  in  1: 0 forces `ifu_lkp_taken`=0 and blocks training. Performance counters still count.
- `bht_clear`  in  1: one-cycle pulse that starts reinitialisation of the table.
- `bht_busy`  out  1: high while a clear sweep is in progress.
- `perf_br_cnt`  out  `CNT_W`: number of resolved branches, saturating.
- `perf_mis_cnt`  out  `CNT_W`: number of mispredicts, saturating.

## Operation
- Each counter encodes SNT=00, WNT=01, WT=10, ST=11.
- Training when `bjp_prdt_en & bht_en & ~bht_busy`:
  - taken: increment, saturating at 11.
  - not taken: decrement, saturating at 00.
- Lookup is combinational from the registered table.
  - `ifu_lkp_taken` = `bht_en & ~bht_busy & ifu_lkp_valid & cnt[idx][1]`.
  - There is no write-to-read bypass. A same-cycle same-index lookup returns the pre-update value.
  - `ifu_lkp_hit_upd` = `ifu_lkp_valid & bjp_prdt_en & (idx == bjp_prdt_index)`.
- Clear FSM, 2 states:
  - IDLE → SWEEP on `bht_clear`. The sweep pointer loads 0.
  - In SWEEP, one entry per cycle is written to WNT (01) and the pointer increments.
  - SWEEP → IDLE after entry `BHT_DEPTH`-1 is written, so a sweep lasts 32 cycles.
  - `bht_clear` during SWEEP restarts the pointer at 0.
  - Training inputs during SWEEP are dropped. Performance counters still count them.
- Performance counters:
  - `perf_br_cnt` += 1 when `bjp_prdt_en`.
  - `perf_mis_cnt` += 1 when `bjp_prdt_flush & bjp_prdt_en`.
  - Both saturate at all-ones and are never cleared by `bht_clear`.

## Timing
- Reset (`reset`=0 at a clock edge):
  - all counters = 01.
  - FSM = IDLE, `bht_busy`=0.
  - `perf_*`=0.
  - `ifu_lkp_taken`=0 while held in reset.
- Training latency is 1 cycle: an update sampled at edge N is visible to lookups from cycle N+1.
- `bht_busy` rises the cycle after `bht_clear` is sampled. It falls 32 cycles later, or later if the clear is restarted.
- A reset asserted mid-sweep aborts the sweep; the table is restored by reset itself.
- `bht_en` deasserting takes effect the same cycle, with no pipeline.

## Structure
- Shared package/defines: `BHT_IDX`, `BHT_DEPTH`, counter encodings `BHT_SNT`/`BHT_WNT`/`BHT_WT`/`BHT_ST`, FSM state codes `BHT_IDLE`/`BHT_SWEEP`.
- Sub-module `lieat_bht_satcnt2`: one 2-bit saturating counter with `inc`, `dec` and `init` inputs. Instantiate it 32 times with a generate loop.
- The FSM and performance counters stay in the top module.

## Test plan
1. Reset, then look up PC 0x80000000 (index 0) → `ifu_lkp_taken`=0, `perf_br_cnt`=0, `perf_mis_cnt`=0.
2. Train index 3 taken twice, then look up PC 0x0C → `ifu_lkp_taken`=1. Train 3 not-taken three times → counter 00, lookup=0.
3. Apply `bjp_prdt_en` with index 7 and a lookup of PC 0x1C in the same cycle, with the counter at WNT → `ifu_lkp_hit_upd`=1, `ifu_lkp_taken`=0 that cycle, and 1 on the next lookup.
4. Saturate all counters to 11, then pulse `bht_clear` → `bht_busy`=1 for 32 cycles. Training during the sweep is ignored and `perf_br_cnt` still increments. Afterward every index reads counter 01.
5. Ten resolutions with `bjp_prdt_flush`=1 on four of them → `perf_br_cnt`=10, `perf_mis_cnt`=4. Preload 0xFFFFFFFF and add one more → value holds.
6. With `bht_en`=0, train index 5 taken four times, then set `bht_en`=1 → index 5 still reads 01 (lookup 0).

Source files
------------

// File: rtl/lieat_bjp_bht_ctrl_pkg.sv
// Shared definitions for the branch history table controller.
// Holds table geometry defaults, 2-bit counter encodings and clear-FSM state codes.
// No ports; imported by lieat_bjp_bht_ctrl and lieat_bht_satcnt2.
package lieat_bjp_bht_ctrl_pkg;

  localparam int XLEN      = 32;
  localparam int BHT_IDX   = 5;
  localparam int BHT_DEPTH = 1 << BHT_IDX;

  // Direction counter encoding: bit[1] is the predicted direction.
  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_cnt_e;

  typedef enum logic {
    BHT_IDLE  = 1'b0,
    BHT_SWEEP = 1'b1
  } bht_state_e;

endpackage

// File: rtl/lieat_bjp_bht_ctrl_satcnt2.sv
// One 2-bit saturating direction counter (SNT/WNT/WT/ST), reset and init to WNT.
// Ports: clock, reset (sync active-low), init (highest priority), inc, dec, cnt (registered value).
// Latency: updates are visible one cycle after the sampling edge; no backpressure.
module lieat_bht_satcnt2 (
  input  logic       clock,
  input  logic       reset,
  input  logic       init,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] cnt
);
  import lieat_bjp_bht_ctrl_pkg::*;

  logic [1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt <= BHT_WNT;
    end else if (init) begin
      r_cnt <= BHT_WNT;
    end else if (inc && (r_cnt != BHT_ST)) begin
      r_cnt <= r_cnt + 2'd1;
    end else if (dec && (r_cnt != BHT_SNT)) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/lieat_bjp_bht_ctrl.sv
// Branch history table: per-cycle IFU direction lookup, BJP-driven training, clear sweep, perf counters.
// Ports: clock/reset; ifu_lkp_* lookup; bjp_prdt_* training/flush; bht_en/bht_clear/bht_busy control; perf_* counters.
// Latency: lookup is combinational from registered state (no bypass); training visible next cycle; no backpressure.
module lieat_bjp_bht_ctrl #(
  parameter int BHT_DEPTH = lieat_bjp_bht_ctrl_pkg::BHT_DEPTH,
  parameter int BHT_IDX   = lieat_bjp_bht_ctrl_pkg::BHT_IDX,
  parameter int CNT_W     = 32
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    ifu_lkp_valid,
  input  logic [lieat_bjp_bht_ctrl_pkg::XLEN-1:0] ifu_lkp_pc,
  output logic                                    ifu_lkp_taken,
  output logic                                    ifu_lkp_hit_upd,
  input  logic                                    bjp_prdt_en,
  input  logic [BHT_IDX-1:0]                      bjp_prdt_index,
  input  logic                                    bjp_prdt_res,
  input  logic                                    bjp_prdt_flush,
  input  logic                                    bht_en,
  input  logic                                    bht_clear,
  output logic                                    bht_busy,
  output logic [CNT_W-1:0]                        perf_br_cnt,
  output logic [CNT_W-1:0]                        perf_mis_cnt
);
  import lieat_bjp_bht_ctrl_pkg::*;

  bht_state_e         r_state;
  bht_state_e         w_state_nxt;
  logic [BHT_IDX-1:0] r_ptr;
  logic [BHT_IDX-1:0] w_ptr_nxt;
  logic [CNT_W-1:0]   r_br_cnt;
  logic [CNT_W-1:0]   r_mis_cnt;

  logic [BHT_IDX-1:0] w_lkp_idx;
  logic               w_busy;
  logic               w_train;
  logic [1:0]         w_cnt [BHT_DEPTH];
  logic               w_unused_pc;

  assign w_lkp_idx   = ifu_lkp_pc[BHT_IDX+1:2];
  assign w_unused_pc = ^{ifu_lkp_pc[XLEN-1:BHT_IDX+2], ifu_lkp_pc[1:0]};
  assign w_busy      = (r_state == BHT_SWEEP);
  // Training is dropped while the table is disabled or being swept.
  assign w_train     = bjp_prdt_en & bht_en & ~w_busy;

  for (genvar g = 0; g < BHT_DEPTH; g++) begin : g_cnt
    logic w_sel;
    assign w_sel = (bjp_prdt_index == BHT_IDX'(g));

    lieat_bht_satcnt2 u_cnt (
      .clock (clock),
      .reset (reset),
      .init  (w_busy && (r_ptr == BHT_IDX'(g))),
      .inc   (w_train &  bjp_prdt_res & w_sel),
      .dec   (w_train & ~bjp_prdt_res & w_sel),
      .cnt   (w_cnt[g])
    );
  end

  // Read the registered table: a same-cycle update to the same index is not forwarded.
  assign ifu_lkp_taken   = bht_en & ~w_busy & ifu_lkp_valid & w_cnt[w_lkp_idx][1];
  assign ifu_lkp_hit_upd = ifu_lkp_valid & bjp_prdt_en & (w_lkp_idx == bjp_prdt_index);
  assign bht_busy        = w_busy;

  // Clear FSM
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= BHT_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      BHT_IDLE: begin
        if (bht_clear) begin
          w_state_nxt = BHT_SWEEP;
          w_ptr_nxt   = '0;
        end
      end
      BHT_SWEEP: begin
        if (bht_clear) begin
          // A new clear restarts the sweep from entry 0.
          w_ptr_nxt = '0;
        end else if (r_ptr == BHT_IDX'(BHT_DEPTH - 1)) begin
          w_state_nxt = BHT_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + BHT_IDX'(1);
        end
      end
      default: begin
        w_state_nxt = BHT_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Performance counters: saturating, untouched by bht_clear or bht_en.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (bjp_prdt_en && (r_br_cnt != '1)) begin
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      end
      if (bjp_prdt_en && bjp_prdt_flush && (r_mis_cnt != '1)) begin
        r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      end
    end
  end

  assign perf_br_cnt  = r_br_cnt;
  assign perf_mis_cnt = r_mis_cnt;

endmodule

// File: tb/tb_lieat_bjp_bht_ctrl.sv
// Testbench for lieat_bjp_bht_ctrl: vector table plus hand-written sweep/perf/reset sequences.
// Two instances share stimulus; the second uses 4-bit perf counters so saturation is reachable.
// Expected results go through a scoreboard queue and are compared mid-cycle after driving.
module tb_lieat_bjp_bht_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  logic [31:0] pc;
  logic        en;
  logic [4:0]  idx;
  logic        res;
  logic        flush;
  logic        bhten;
  logic        clear;

  logic        taken, hit, busy;
  logic [31:0] br, mis;
  logic        s_taken, s_hit, s_busy;
  logic [3:0]  s_br, s_mis;

  always #5 clock = ~clock;

  lieat_bjp_bht_ctrl u_dut (
    .clock(clock), .reset(reset),
    .ifu_lkp_valid(valid), .ifu_lkp_pc(pc),
    .ifu_lkp_taken(taken), .ifu_lkp_hit_upd(hit),
    .bjp_prdt_en(en), .bjp_prdt_index(idx), .bjp_prdt_res(res), .bjp_prdt_flush(flush),
    .bht_en(bhten), .bht_clear(clear), .bht_busy(busy),
    .perf_br_cnt(br), .perf_mis_cnt(mis)
  );

  lieat_bjp_bht_ctrl #(.CNT_W(4)) u_sat (
    .clock(clock), .reset(reset),
    .ifu_lkp_valid(valid), .ifu_lkp_pc(pc),
    .ifu_lkp_taken(s_taken), .ifu_lkp_hit_upd(s_hit),
    .bjp_prdt_en(en), .bjp_prdt_index(idx), .bjp_prdt_res(res), .bjp_prdt_flush(flush),
    .bht_en(bhten), .bht_clear(clear), .bht_busy(s_busy),
    .perf_br_cnt(s_br), .perf_mis_cnt(s_mis)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        en;
    logic [4:0]  idx;
    logic        res;
    logic        flush;
    logic        bhten;
    logic        clear;
    logic        e_taken;
    logic        e_hit;
    logic        e_busy;
  } vec_t;

  typedef struct {
    logic        taken;
    logic        hit;
    logic        busy;
    logic [31:0] br;
    logic [31:0] mis;
    logic [3:0]  sbr;
    logic [3:0]  smis;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vt[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int unsigned m_br   = 0;
  int unsigned m_mis  = 0;

  function automatic logic [3:0] sat4(input int unsigned v);
    if (v > 15) return 4'hF;
    return v[3:0];
  endfunction

  function automatic vec_t mk(input logic v_valid, input logic [31:0] v_pc, input logic v_en,
                              input logic [4:0] v_idx, input logic v_res, input logic v_flush,
                              input logic v_bhten, input logic e_taken, input logic e_hit);
    vec_t v;
    v.valid = v_valid; v.pc = v_pc; v.en = v_en; v.idx = v_idx; v.res = v_res;
    v.flush = v_flush; v.bhten = v_bhten; v.clear = 1'b0;
    v.e_taken = e_taken; v.e_hit = e_hit; v.e_busy = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Drive one cycle at the falling edge, compare 1 ns later, then account for the rising edge.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clock);
    reset = 1'b1; valid = v.valid; pc = v.pc; en = v.en; idx = v.idx;
    res = v.res; flush = v.flush; bhten = v.bhten; clear = v.clear;
    e.taken = v.e_taken; e.hit = v.e_hit; e.busy = v.e_busy;
    e.br = m_br; e.mis = m_mis; e.sbr = sat4(m_br); e.smis = sat4(m_mis);
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    chk("lkp_taken", 32'(taken), 32'(e.taken));
    chk("lkp_hit_upd", 32'(hit), 32'(e.hit));
    chk("bht_busy", 32'(busy), 32'(e.busy));
    chk("perf_br_cnt", br, e.br);
    chk("perf_mis_cnt", mis, e.mis);
    chk("sat_taken", 32'(s_taken), 32'(e.taken));
    chk("sat_br_cnt", 32'(s_br), 32'(e.sbr));
    chk("sat_mis_cnt", 32'(s_mis), 32'(e.smis));
    if (v.en) begin
      m_br++;
      if (v.flush) m_mis++;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; valid = 1'b1; pc = 32'h8000_0000; en = 1'b0; idx = '0;
    res = 1'b0; flush = 1'b0; bhten = 1'b1; clear = 1'b0;
    @(negedge clock);
    chk("rst_taken", 32'(taken), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_br_cnt", br, 32'd0);
    chk("rst_mis_cnt", mis, 32'd0);
    m_br = 0;
    m_mis = 0;
  endtask

  initial begin
    vec_t v;
    reset = 1'b0; valid = 1'b0; pc = '0; en = 1'b0; idx = '0;
    res = 1'b0; flush = 1'b0; bhten = 1'b1; clear = 1'b0;

    //          valid pc            en idx res flush bhten  taken hit
    vt.push_back(mk(1, 32'h8000_0000, 0, 0, 0, 0, 1,  0, 0));
    vt.push_back(mk(0, 32'h0000_0000, 1, 3, 1, 0, 1,  0, 0));
    vt.push_back(mk(0, 32'h0000_0000, 1, 3, 1, 1, 1,  0, 0));
    vt.push_back(mk(1, 32'h0000_000C, 0, 0, 0, 0, 1,  1, 0));
    vt.push_back(mk(0, 32'h0000_0000, 1, 3, 0, 0, 1,  0, 0));
    vt.push_back(mk(1, 32'h0000_000C, 1, 3, 0, 0, 1,  1, 1));
    vt.push_back(mk(1, 32'h0000_000C, 1, 3, 0, 1, 1,  0, 1));
    vt.push_back(mk(1, 32'h0000_000C, 0, 0, 0, 0, 1,  0, 0));
    vt.push_back(mk(1, 32'h0000_001C, 1, 7, 1, 1, 1,  0, 1));
    vt.push_back(mk(1, 32'h0000_001C, 0, 0, 0, 0, 1,  1, 0));
    vt.push_back(mk(1, 32'h0000_000C, 1, 7, 1, 0, 1,  0, 0));
    vt.push_back(mk(0, 32'h0000_001C, 0, 0, 0, 0, 1,  0, 0));
    for (int k = 0; k < 4; k++)
      vt.push_back(mk(1, 32'h0000_0014, 1, 5, 1, 0, 0,  0, 1));
    vt.push_back(mk(1, 32'h0000_001C, 0, 0, 0, 0, 0,  0, 0));
    vt.push_back(mk(1, 32'h0000_0014, 0, 0, 0, 0, 1,  0, 0));
    vt.push_back(mk(1, 32'h8000_001C, 0, 0, 0, 0, 1,  1, 0));
    vt.push_back(mk(1, 32'h0000_0014, 1, 5, 1, 0, 1,  0, 1));
    vt.push_back(mk(1, 32'h0000_0014, 0, 0, 0, 0, 1,  1, 0));
    vt.push_back(mk(0, 32'h0000_0000, 0, 0, 0, 1, 1,  0, 0));

    do_reset();
    foreach (vt[i]) step(vt[i]);

    // Saturate every entry to ST, then confirm each predicts taken.
    for (int i = 0; i < 32; i++)
      for (int k = 0; k < 3; k++)
        step(mk(0, 32'h0, 1, 5'(i), 1, 0, 1, 0, 0));
    for (int i = 0; i < 32; i++)
      step(mk(1, 32'(i) << 2, 0, 0, 0, 0, 1, 1, 0));

    // Clear sweep, restarted after 10 busy cycles; training on index 0 must be ignored.
    v = mk(0, 32'h0, 0, 0, 0, 0, 1, 0, 0);
    v.clear = 1'b1;
    step(v);
    for (int j = 1; j <= 42; j++) begin
      v = mk(1, 32'h0, 1, 0, 1, (j % 3) == 0, 1, 0, 1);
      v.clear  = (j == 10);
      v.e_busy = 1'b1;
      step(v);
    end
    // Every entry must now be WNT: taken step reads 0, following not-taken step reads 1.
    for (int i = 0; i < 32; i++) begin
      step(mk(1, 32'(i) << 2, 1, 5'(i), 1, 0, 1, 0, 1));
      step(mk(1, 32'(i) << 2, 1, 5'(i), 0, 0, 1, 1, 1));
    end

    // Performance counters from a fresh reset.
    do_reset();
    for (int i = 0; i < 10; i++)
      step(mk(0, 32'h0, 1, 5'(i), i[0], (i == 1) || (i == 3) || (i == 6) || (i == 8), 1, 0, 0));
    step(mk(0, 32'h0, 0, 0, 0, 1, 1, 0, 0));
    chk("br_after_10", br, 32'd10);
    chk("mis_after_10", mis, 32'd4);
    for (int i = 0; i < 13; i++)
      step(mk(0, 32'h0, 1, 5'd9, 0, 1, 1, 0, 0));
    step(mk(0, 32'h0, 0, 0, 0, 0, 1, 0, 0));
    chk("sat_br_hold", 32'(s_br), 32'hF);
    chk("sat_mis_hold", 32'(s_mis), 32'hF);
    chk("br_after_23", br, 32'd23);

    // Reset in the middle of a sweep aborts it and restores the table.
    v = mk(0, 32'h0, 1, 2, 1, 0, 1, 0, 0);
    v.clear = 1'b1;
    step(v);
    for (int j = 0; j < 5; j++) begin
      v = mk(1, 32'h8, 0, 0, 0, 0, 1, 0, 0);
      v.e_busy = 1'b1;
      step(v);
    end
    do_reset();
    step(mk(1, 32'h8, 1, 2, 1, 0, 1, 0, 1));
    step(mk(1, 32'h8, 0, 0, 0, 0, 1, 1, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
